// File: rtl/alu_result_skid.sv
// -----------------------------------------------------------------------------
// alu_result_skid
//   Registered output stage behind the combinational ALU. Each beat carries the
//   ALU result (y, zero) and a destination tag, and moves under a valid/ready
//   handshake. A two-entry skid buffer (main + skid register) gives one beat per
//   cycle while keeping in_ready a pure register output. The stage also counts
//   accepted results and zero results, and latches a sticky error when the
//   ALU zero flag disagrees with the result value.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              upstream handshake (in_ready registered)
//   in_y, in_zero, in_tag          incoming beat
//   out_valid/out_ready            downstream handshake (out_valid registered)
//   out_y, out_zero, out_tag       registered beat (main register)
//   cnt_clr                        synchronous clear of counters and err_zero
//   accept_cnt                     accepted beats, wraps
//   zero_cnt                       accepted beats with in_zero=1, saturates
//   err_zero                       sticky zero-flag inconsistency
// -----------------------------------------------------------------------------
module alu_result_skid #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_zero,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] accept_cnt,
   output logic [CNT_W-1:0] zero_cnt,
   output logic             err_zero
);

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             zero;
      logic [TAG_W-1:0] tag;
   } beat_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;
   beat_t  main_q, skid_q, in_beat;
   logic   in_fire, out_fire;
   logic   load_main_in, load_main_skid, load_skid;

   assign in_beat   = {in_y, in_zero, in_tag};
   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign out_y     = main_q.y;
   assign out_zero  = main_q.zero;
   assign out_tag   = main_q.tag;

   // ---------------------------------------------------------------------------
   // Next-state / register-load decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt    = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               // Downstream stalled: park the new beat behind the main entry.
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so in_fire cannot occur.
            if (out_fire) begin
               state_nxt      = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, registered in_ready and data registers
   // ---------------------------------------------------------------------------
   // in_ready is held low through reset and only rises on the first edge after
   // release, so it is not simply (state != FULL).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
         if (load_main_in) begin
            main_q <= in_beat;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_beat;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Statistics; cnt_clr takes priority over a same-cycle accept
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_cnt <= '0;
         zero_cnt   <= '0;
         err_zero   <= 1'b0;
      end else if (cnt_clr) begin
         accept_cnt <= '0;
         zero_cnt   <= '0;
         err_zero   <= 1'b0;
      end else if (in_fire) begin
         accept_cnt <= accept_cnt + 1'b1;
         if (in_zero && (zero_cnt != {CNT_W{1'b1}})) begin
            zero_cnt <= zero_cnt + 1'b1;
         end
         if (in_zero != (in_y == {WIDTH{1'b0}})) begin
            err_zero <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_skid.sv
// -----------------------------------------------------------------------------
// tb_alu_result_skid
//   Directed bench for alu_result_skid. A queue-based reference model tracks
//   the beats held by the stage and the statistics; a negedge process compares
//   every output against it each cycle. Literal checks pin the key scenarios.
//   CNT_W is reduced to 8 so counter saturation and wrap are reachable quickly.
// -----------------------------------------------------------------------------
module tb_alu_result_skid;
   localparam int WIDTH = 32;
   localparam int TAG_W = 5;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_y = '0;
   logic             in_zero = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_y;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;
   logic             cnt_clr = 1'b0;
   logic [CNT_W-1:0] accept_cnt;
   logic [CNT_W-1:0] zero_cnt;
   logic             err_zero;

   alu_result_skid #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_zero(in_zero), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_zero(out_zero), .out_tag(out_tag),
      .cnt_clr(cnt_clr), .accept_cnt(accept_cnt), .zero_cnt(zero_cnt),
      .err_zero(err_zero)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [WIDTH-1:0] y;
      logic             z;
      logic [TAG_W-1:0] t;
   } bt_t;

   bt_t q[$];
   bit  m_rdy = 0;
   int  m_acc = 0;
   int  m_zc  = 0;
   bit  m_err = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_rdy = 0; m_acc = 0; m_zc = 0; m_err = 0;
      end else begin
         bit fi, fo;
         bt_t b;
         cyc++;
         fi = in_valid && m_rdy;
         fo = (q.size() > 0) && out_ready;
         if (fo) void'(q.pop_front());
         if (fi) begin
            b.y = in_y; b.z = in_zero; b.t = in_tag;
            q.push_back(b);
         end
         if (cnt_clr) begin
            m_acc = 0; m_zc = 0; m_err = 0;
         end else if (fi) begin
            m_acc = (m_acc + 1) % (CMAX + 1);
            if (in_zero && m_zc < CMAX) m_zc++;
            if (in_zero != (in_y == 0)) m_err = 1;
         end
         m_rdy = (q.size() < 2);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
         chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
         if (q.size() > 0) begin
            chk("out_y", {32'd0, out_y}, {32'd0, q[0].y});
            chk("out_zero", {63'd0, out_zero}, {63'd0, q[0].z});
            chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].t});
         end
         chk("accept_cnt", {56'd0, accept_cnt}, 64'(m_acc));
         chk("zero_cnt", {56'd0, zero_cnt}, 64'(m_zc));
         chk("err_zero", {63'd0, err_zero}, {63'd0, m_err});
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Offer one beat and hold it until accepted (bounded); returns at edge+1.
   task automatic send(input logic [WIDTH-1:0] y, input logic z, input logic [TAG_W-1:0] t);
      bit acc;
      acc = 0;
      in_valid = 1'b1; in_y = y; in_zero = z; in_tag = t;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: beat tag %0d not accepted within 50 cycles", t);
      end
      in_valid = 1'b0;
   endtask

   task automatic clr();
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      // 1. reset, then one beat
      repeat (3) tick();
      rst = 1'b0;
      chk("lit_rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("lit_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("lit_rst_out_y", {32'd0, out_y}, 64'd0);
      chk("lit_rst_accept", {56'd0, accept_cnt}, 64'd0);
      send(32'h5, 1'b0, 5'd3);
      chk("lit_t1_valid", {63'd0, out_valid}, 64'd1);
      chk("lit_t1_y", {32'd0, out_y}, 64'd5);
      chk("lit_t1_zero", {63'd0, out_zero}, 64'd0);
      chk("lit_t1_tag", {59'd0, out_tag}, 64'd3);
      chk("lit_t1_acc", {56'd0, accept_cnt}, 64'd1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // 2. stall with three beats offered
      send(32'hA, 1'b0, 5'd10);
      send(32'hB, 1'b0, 5'd11);
      in_valid = 1'b1; in_y = 32'hC; in_zero = 1'b0; in_tag = 5'd12;
      repeat (3) tick();
      chk("lit_t2_full_rdy", {63'd0, in_ready}, 64'd0);
      chk("lit_t2_hold_y", {32'd0, out_y}, 64'hA);
      chk("lit_t2_hold_tag", {59'd0, out_tag}, 64'd10);
      out_ready = 1'b1;
      send(32'hC, 1'b0, 5'd12);
      chk("lit_t2_last_y", {32'd0, out_y}, 64'hC);
      tick();
      chk("lit_t2_drained", {63'd0, out_valid}, 64'd0);

      // 3. stream 100 beats at full rate
      clr();
      c0 = cyc;
      for (int i = 0; i < 100; i++) send(32'(i * 3 + 1), 1'b0, 5'(i));
      chk("lit_t3_cycles", 64'(cyc - c0), 64'd100);
      tick();
      chk("lit_t3_acc", {56'd0, accept_cnt}, 64'd100);
      out_ready = 1'b0;

      // 4. zero-flag statistics and clear priority
      out_ready = 1'b1;
      clr();
      send(32'h0, 1'b1, 5'd1);
      send(32'h7, 1'b1, 5'd2);
      chk("lit_t4_zc", {56'd0, zero_cnt}, 64'd2);
      chk("lit_t4_err", {63'd0, err_zero}, 64'd1);
      cnt_clr = 1'b1;
      send(32'h9, 1'b1, 5'd3);
      cnt_clr = 1'b0;
      chk("lit_t4_clr_acc", {56'd0, accept_cnt}, 64'd0);
      chk("lit_t4_clr_zc", {56'd0, zero_cnt}, 64'd0);
      chk("lit_t4_clr_err", {63'd0, err_zero}, 64'd0);

      // 5. saturation and wrap (CNT_W=8: all-ones is 0xFF)
      for (int i = 0; i < CMAX - 1; i++) send(32'h0, 1'b1, 5'(i));
      chk("lit_t5_pre_zc", {56'd0, zero_cnt}, 64'hFE);
      send(32'h0, 1'b1, 5'd1);
      chk("lit_t5_zc_ff", {56'd0, zero_cnt}, 64'hFF);
      chk("lit_t5_acc_ff", {56'd0, accept_cnt}, 64'hFF);
      send(32'h0, 1'b1, 5'd2);
      chk("lit_t5_acc_wrap", {56'd0, accept_cnt}, 64'd0);
      chk("lit_t5_zc_sat", {56'd0, zero_cnt}, 64'hFF);
      send(32'h0, 1'b1, 5'd3);
      chk("lit_t5_acc_1", {56'd0, accept_cnt}, 64'd1);
      chk("lit_t5_zc_sat2", {56'd0, zero_cnt}, 64'hFF);
      tick();

      // 6. reset while FULL
      out_ready = 1'b0;
      send(32'h11, 1'b0, 5'd21);
      send(32'h22, 1'b0, 5'd22);
      in_valid = 1'b1; in_y = 32'h33; in_tag = 5'd23;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("lit_t6_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("lit_t6_rst_rdy", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("lit_t6_no_stale", {63'd0, out_valid}, 64'd0);
      chk("lit_t6_acc0", {56'd0, accept_cnt}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
